// File: rtl/alu_seq.sv
// alu_seq: nibble-serial ALU sequencer.
//
// Drives one external 4-bit lookup-ROM ALU slice for NIBBLES consecutive cycles
// to build a WIDTH-bit result, LSB nibble first. Carry is chained through the
// slice's prop/gen outputs. The zero flag is accumulated from the slice's
// per-nibble zero output.
//
// Ports:
//   CLK, N_RST             clock, asynchronous active-low reset
//   REQ_VALID/REQ_READY    request handshake; REQ_READY is high only in IDLE
//   REQ_OP/A/B/CIN         opcode, operands, carry-in (ADD/SUB only)
//   RESP_VALID/RESP_READY  response handshake; data held until taken
//   RESP_OUT, RESP_Z/C/N/V result and flags
//   SLICE_A/B/OP/C_IN      registered drive to the slice (zero outside RUN)
//   SLICE_OUT              slice data {-, zero, gen, prop, out[3:0]}
//
// Opcode encoding (3 bits):
//   0 NOP0, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOT, 7 NOP1
module alu_seq #(
    parameter  int NIBBLES = 8,
    localparam int WIDTH   = 4 * NIBBLES
) (
    input  logic             CLK,
    input  logic             N_RST,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [2:0]       REQ_OP,
    input  logic [WIDTH-1:0] REQ_A,
    input  logic [WIDTH-1:0] REQ_B,
    input  logic             REQ_CIN,
    output logic             RESP_VALID,
    input  logic             RESP_READY,
    output logic [WIDTH-1:0] RESP_OUT,
    output logic             RESP_Z,
    output logic             RESP_C,
    output logic             RESP_N,
    output logic             RESP_V,
    output logic [3:0]       SLICE_A,
    output logic [3:0]       SLICE_B,
    output logic [2:0]       SLICE_OP,
    output logic             SLICE_C_IN,
    input  logic [7:0]       SLICE_OUT
);

    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic [2:0]       op_q;
    logic             carry_q, zacc_q;
    logic             a_msb, b_msb;

    logic             run, arith, last;
    logic [WIDTH-1:0] nib_w, res_next;
    logic             carry_next, zacc_next, b_eff_msb;
    logic             unused_bit7;

    assign unused_bit7 = SLICE_OUT[7];

    assign run   = (state == ST_RUN);
    assign arith = (op_q == ALU_ADD) || (op_q == ALU_SUB);
    assign last  = (cnt == CW'(NIBBLES - 1));

    // New nibble enters at the top; after NIBBLES shifts the first nibble sits in [3:0].
    assign nib_w      = WIDTH'(SLICE_OUT[3:0]);
    assign res_next   = (res_sh >> 4) | (nib_w << (WIDTH - 4));
    assign carry_next = arith & (SLICE_OUT[5] | (SLICE_OUT[4] & carry_q));
    assign zacc_next  = zacc_q & SLICE_OUT[6];
    // Subtract is A + ~B + cin, so overflow compares against the inverted B msb.
    assign b_eff_msb  = (op_q == ALU_SUB) ? ~b_msb : b_msb;

    assign REQ_READY  = (state == ST_IDLE);
    assign RESP_VALID = (state == ST_DONE);

    // Slice inputs come only from registers, forced to 0 outside RUN.
    assign SLICE_A    = run ? a_sh[3:0] : 4'd0;
    assign SLICE_B    = run ? b_sh[3:0] : 4'd0;
    assign SLICE_OP   = run ? op_q      : 3'd0;
    assign SLICE_C_IN = run & carry_q;

    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            op_q     <= 3'd0;
            carry_q  <= 1'b0;
            zacc_q   <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            RESP_OUT <= '0;
            RESP_Z   <= 1'b0;
            RESP_C   <= 1'b0;
            RESP_N   <= 1'b0;
            RESP_V   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (REQ_VALID) begin
                        a_sh    <= REQ_A;
                        b_sh    <= REQ_B;
                        op_q    <= REQ_OP;
                        carry_q <= ((REQ_OP == ALU_ADD) || (REQ_OP == ALU_SUB)) & REQ_CIN;
                        zacc_q  <= 1'b1;
                        cnt     <= '0;
                        a_msb   <= REQ_A[WIDTH-1];
                        b_msb   <= REQ_B[WIDTH-1];
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh    <= a_sh >> 4;
                    b_sh    <= b_sh >> 4;
                    res_sh  <= res_next;
                    carry_q <= carry_next;
                    zacc_q  <= zacc_next;
                    cnt     <= cnt + CW'(1);
                    if (last) begin
                        // Flags are captured with the final nibble so RESP_* stays
                        // untouched while the next operation runs.
                        state    <= ST_DONE;
                        RESP_OUT <= res_next;
                        RESP_Z   <= zacc_next;
                        RESP_C   <= carry_next;
                        RESP_N   <= res_next[WIDTH-1];
                        RESP_V   <= arith & (a_msb == b_eff_msb) &
                                    (res_next[WIDTH-1] != a_msb);
                    end
                end
                ST_DONE: begin
                    if (RESP_READY) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq with a behavioural
// model of the 4-bit lookup-ROM slice.
module tb_alu_seq;

    localparam int NIB = 8;
    localparam logic [2:0] OP_NOP0 = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_AND = 3'd3,
                           OP_OR = 3'd4, OP_XOR = 3'd5, OP_NOT = 3'd6, OP_NOP1 = 3'd7;

    logic        CLK = 1'b0;
    logic        N_RST;
    logic        REQ_VALID, REQ_READY, REQ_CIN;
    logic [2:0]  REQ_OP;
    logic [31:0] REQ_A, REQ_B;
    logic        RESP_VALID, RESP_READY;
    logic [31:0] RESP_OUT;
    logic        RESP_Z, RESP_C, RESP_N, RESP_V;
    logic [3:0]  SLICE_A, SLICE_B;
    logic [2:0]  SLICE_OP;
    logic        SLICE_C_IN;
    logic [7:0]  SLICE_OUT;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    alu_seq #(.NIBBLES(NIB)) dut (
        .CLK(CLK), .N_RST(N_RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
        .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_CIN(REQ_CIN),
        .RESP_VALID(RESP_VALID), .RESP_READY(RESP_READY), .RESP_OUT(RESP_OUT),
        .RESP_Z(RESP_Z), .RESP_C(RESP_C), .RESP_N(RESP_N), .RESP_V(RESP_V),
        .SLICE_A(SLICE_A), .SLICE_B(SLICE_B), .SLICE_OP(SLICE_OP),
        .SLICE_C_IN(SLICE_C_IN), .SLICE_OUT(SLICE_OUT)
    );

    // Slice ROM model: data {-, zero, gen, prop, out[3:0]}.
    logic [3:0] sl_bb, sl_out;
    logic [4:0] sl_ab;
    always_comb begin
        sl_bb  = (SLICE_OP == OP_SUB) ? ~SLICE_B : SLICE_B;
        sl_ab  = {1'b0, SLICE_A} + {1'b0, sl_bb};
        sl_out = 4'd0;
        case (SLICE_OP)
            OP_ADD, OP_SUB: sl_out = sl_ab[3:0] + {3'd0, SLICE_C_IN};
            OP_AND:         sl_out = SLICE_A & SLICE_B;
            OP_OR:          sl_out = SLICE_A | SLICE_B;
            OP_XOR:         sl_out = SLICE_A ^ SLICE_B;
            OP_NOT:         sl_out = ~SLICE_A;
            default:        sl_out = 4'd0;
        endcase
        SLICE_OUT = {1'b0, (sl_out == 4'd0),
                     ((SLICE_OP == OP_ADD) || (SLICE_OP == OP_SUB)) && (sl_ab > 5'd15),
                     ((SLICE_OP == OP_ADD) || (SLICE_OP == OP_SUB)) && (sl_ab == 5'd15),
                     sl_out};
    end

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] out;
        logic [3:0]  zcnv;
    } vec_t;

    // Waits (bounded) for REQ_READY, presents a request and returns #1 after the accepting edge.
    task automatic start_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic cin);
        int t = 0;
        while (!REQ_READY && t < 50) begin @(posedge CLK); #1; t++; end
        REQ_OP = op; REQ_A = a; REQ_B = b; REQ_CIN = cin; REQ_VALID = 1'b1;
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
    endtask

    // Counts edges from the accepting edge until RESP_VALID (bounded at 40).
    task automatic wait_resp(output int lat);
        lat = 0;
        while (!RESP_VALID && lat < 40) begin @(posedge CLK); #1; lat++; end
    endtask

    task automatic ack();
        RESP_READY = 1'b1;
        @(posedge CLK); #1;
        RESP_READY = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, output int lat, output logic [31:0] out,
                           output logic [3:0] zcnv);
        start_req(v.op, v.a, v.b, v.cin);
        wait_resp(lat);
        out  = RESP_OUT;
        zcnv = {RESP_Z, RESP_C, RESP_N, RESP_V};
        ack();
    endtask

    task automatic test_reset();
        logic [49:0] obs;
        N_RST = 1'b0; REQ_VALID = 1'b0; REQ_OP = 3'd0; REQ_A = '0; REQ_B = '0;
        REQ_CIN = 1'b0; RESP_READY = 1'b0;
        #1;
        obs = {REQ_READY, RESP_VALID, RESP_OUT, RESP_Z, RESP_C, RESP_N, RESP_V,
               SLICE_A, SLICE_B, SLICE_OP, SLICE_C_IN};
        n_checks++;
        if (obs !== {1'b1, 1'b0, 32'd0, 4'd0, 4'd0, 4'd0, 3'd0, 1'b0}) begin
            n_fail++; $display("FAIL reset_state: got %h, expected %h", obs,
                               {1'b1, 1'b0, 32'd0, 4'd0, 4'd0, 4'd0, 3'd0, 1'b0});
        end
        repeat (2) @(posedge CLK);
        #3 N_RST = 1'b1;
        @(posedge CLK); #1;
        n_checks++;
        if ({REQ_READY, RESP_VALID} !== 2'b10) begin
            n_fail++; $display("FAIL reset_release: ready/valid got %b, expected 10",
                               {REQ_READY, RESP_VALID});
        end
    endtask

    task automatic test_add();
        vec_t tv[3];
        int lat; logic [31:0] out; logic [3:0] f;
        tv = '{'{OP_ADD, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 4'b0000},
               '{OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b1100},
               '{OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b0011}};
        for (int i = 0; i < 3; i++) begin
            run_vec(tv[i], lat, out, f);
            n_checks++;
            if (lat !== NIB) begin
                n_fail++; $display("FAIL add[%0d] latency: got %0d edges, expected %0d", i, lat, NIB);
            end
            n_checks++;
            if ({out, f} !== {tv[i].out, tv[i].zcnv}) begin
                n_fail++; $display("FAIL add[%0d] result: got out=%h zcnv=%b, expected out=%h zcnv=%b",
                                   i, out, f, tv[i].out, tv[i].zcnv);
            end
        end
    endtask

    task automatic test_sub();
        vec_t tv[3];
        int lat; logic [31:0] out; logic [3:0] f;
        tv = '{'{OP_SUB, 32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 4'b0100},
               '{OP_SUB, 32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 4'b0010},
               '{OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 4'b0101}};
        for (int i = 0; i < 3; i++) begin
            run_vec(tv[i], lat, out, f);
            n_checks++;
            if (lat !== NIB || {out, f} !== {tv[i].out, tv[i].zcnv}) begin
                n_fail++; $display("FAIL sub[%0d]: got lat=%0d out=%h zcnv=%b, expected lat=%0d out=%h zcnv=%b",
                                   i, lat, out, f, NIB, tv[i].out, tv[i].zcnv);
            end
        end
    endtask

    // CIN=1 on the non-arithmetic ops checks that carry is forced to 0.
    task automatic test_logic();
        vec_t tv[6];
        int lat; logic [31:0] out; logic [3:0] f;
        tv = '{'{OP_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 1'b1, 32'h00F0_1200, 4'b0000},
               '{OP_OR,   32'hF0F0_1234, 32'h0FF0_FF00, 1'b1, 32'hFFF0_FF34, 4'b0010},
               '{OP_XOR,  32'hF0F0_1234, 32'h0FF0_FF00, 1'b1, 32'hFF00_ED34, 4'b0010},
               '{OP_NOT,  32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 32'h0000_0000, 4'b1000},
               '{OP_NOP0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 4'b1000},
               '{OP_NOP1, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, 4'b1000}};
        for (int i = 0; i < 6; i++) begin
            run_vec(tv[i], lat, out, f);
            n_checks++;
            if (lat !== NIB || {out, f} !== {tv[i].out, tv[i].zcnv}) begin
                n_fail++; $display("FAIL logic[%0d]: got lat=%0d out=%h zcnv=%b, expected lat=%0d out=%h zcnv=%b",
                                   i, lat, out, f, NIB, tv[i].out, tv[i].zcnv);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        start_req(OP_ADD, 32'h0000_0100, 32'h0000_0023, 1'b0);
        wait_resp(lat);
        // Next request is presented while the response is stalled.
        REQ_OP = OP_SUB; REQ_A = 32'd10; REQ_B = 32'd4; REQ_CIN = 1'b1; REQ_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            n_checks++;
            if ({RESP_VALID, REQ_READY, RESP_OUT} !== {1'b1, 1'b0, 32'h0000_0123}) begin
                n_fail++; $display("FAIL stall[%0d]: got valid=%b ready=%b out=%h, expected 1 0 00000123",
                                   i, RESP_VALID, REQ_READY, RESP_OUT);
            end
        end
        RESP_READY = 1'b1;
        @(posedge CLK); #1;
        RESP_READY = 1'b0;
        n_checks++;
        if ({REQ_READY, RESP_VALID, RESP_OUT} !== {1'b1, 1'b0, 32'h0000_0123}) begin
            n_fail++; $display("FAIL idle_after_ack: got ready=%b valid=%b out=%h, expected 1 0 00000123",
                               REQ_READY, RESP_VALID, RESP_OUT);
        end
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        n_checks++;
        if (REQ_READY !== 1'b0) begin
            n_fail++; $display("FAIL accept_after_ack: ready got %b, expected 0", REQ_READY);
        end
        wait_resp(lat);
        n_checks++;
        if (lat !== NIB || {RESP_OUT, RESP_Z, RESP_C, RESP_N, RESP_V} !== {32'd6, 4'b0100}) begin
            n_fail++; $display("FAIL queued_sub: got lat=%0d out=%h zcnv=%b, expected lat=%0d out=00000006 zcnv=0100",
                               lat, RESP_OUT, {RESP_Z, RESP_C, RESP_N, RESP_V}, NIB);
        end
        ack();
    endtask

    task automatic test_reset_mid_run();
        logic [49:0] obs;
        int lat;
        bit seen = 0;
        start_req(OP_ADD, 32'h1234_5678, 32'h1111_1111, 1'b0);
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if ({SLICE_A, SLICE_B, SLICE_OP} !== {4'h5, 4'h1, OP_ADD}) begin
            n_fail++; $display("FAIL nibble3_drive: got a=%h b=%h op=%0d, expected a=5 b=1 op=1",
                               SLICE_A, SLICE_B, SLICE_OP);
        end
        #1 N_RST = 1'b0;
        #1;
        obs = {REQ_READY, RESP_VALID, RESP_OUT, RESP_Z, RESP_C, RESP_N, RESP_V,
               SLICE_A, SLICE_B, SLICE_OP, SLICE_C_IN};
        n_checks++;
        if (obs !== {1'b1, 1'b0, 32'd0, 4'd0, 4'd0, 4'd0, 3'd0, 1'b0}) begin
            n_fail++; $display("FAIL reset_mid_run: got %h, expected %h", obs,
                               {1'b1, 1'b0, 32'd0, 4'd0, 4'd0, 4'd0, 3'd0, 1'b0});
        end
        @(posedge CLK);
        #3 N_RST = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK); #1;
            if (RESP_VALID !== 1'b0) seen = 1;
        end
        n_checks++;
        if (seen) begin
            n_fail++; $display("FAIL aborted_resp: response seen after reset abort, expected none");
        end
        start_req(OP_ADD, 32'h1234_5678, 32'h1111_1111, 1'b0);
        wait_resp(lat);
        n_checks++;
        if (lat !== NIB || {RESP_OUT, RESP_Z, RESP_C, RESP_N, RESP_V} !== {32'h2345_6789, 4'b0000}) begin
            n_fail++; $display("FAIL add_after_reset: got lat=%0d out=%h zcnv=%b, expected lat=%0d out=23456789 zcnv=0000",
                               lat, RESP_OUT, {RESP_Z, RESP_C, RESP_N, RESP_V}, NIB);
        end
        ack();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_backpressure();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
